alu_unit: RTL and testbench

Integer functional unit that sits directly downstream of the ALU reservation station. It accepts one issued instruction per `in_valid` pulse and evaluates it: arithmetic, logic, shift, compare, LUI/AUIPC, branch and JAL/JALR. Each result is queued in a 2-entry result buffer, then presented to the CDB arbiter through a request/grant handshake. Branch and jump resolution (taken, target, mispredict) travels with the result so the ROB can trigger recovery.

---
 rtl/alu_unit_pkg.sv | 34 +++
 rtl/alu_core.sv | 63 ++++++
 rtl/alu_unit.sv | 84 ++++++++
 tb/tb_alu_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_unit_pkg.sv
// rtl/alu_unit_pkg.sv - op encodings, widths and result record shared by the ALU unit.
package alu_unit_pkg;

    localparam int ROB_ID_WIDTH = 4;
    localparam int OP_WIDTH     = 5;

    // Code 0 and codes above OP_JALR are unknown ops: value 0, never a branch.
    typedef enum logic [OP_WIDTH-1:0] {
        OP_NONE  = 5'd0,
        OP_ADD   = 5'd1,  OP_SUB   = 5'd2,  OP_AND   = 5'd3,  OP_OR    = 5'd4,
        OP_XOR   = 5'd5,  OP_SLL   = 5'd6,  OP_SRL   = 5'd7,  OP_SRA   = 5'd8,
        OP_SLT   = 5'd9,  OP_SLTU  = 5'd10, OP_ADDI  = 5'd11, OP_ANDI  = 5'd12,
        OP_ORI   = 5'd13, OP_XORI  = 5'd14, OP_SLLI  = 5'd15, OP_SRLI  = 5'd16,
        OP_SRAI  = 5'd17, OP_SLTI  = 5'd18, OP_SLTIU = 5'd19, OP_LUI   = 5'd20,
        OP_AUIPC = 5'd21, OP_BEQ   = 5'd22, OP_BNE   = 5'd23, OP_BLT   = 5'd24,
        OP_BGE   = 5'd25, OP_BLTU  = 5'd26, OP_BGEU  = 5'd27, OP_JAL   = 5'd28,
        OP_JALR  = 5'd29
    } alu_op_e;

    typedef struct packed {
        logic [ROB_ID_WIDTH-1:0] rob_id;
        logic [31:0]             value;
        logic                    is_branch;
        logic                    taken;
        logic [31:0]             target;
        logic                    mispredict;
    } alu_result_t;

    function automatic logic uses_imm(input logic [OP_WIDTH-1:0] op);
        return op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI,
                          OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU};
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational evaluation of one ALU/branch/jump op.
module alu_core
    import alu_unit_pkg::*;
(
    input  logic [OP_WIDTH-1:0] op,
    input  logic [31:0]         vj,
    input  logic [31:0]         vk,
    input  logic [31:0]         imm,
    input  logic [31:0]         pc,
    input  logic [31:0]         pred_target,
    output logic [31:0]         value,
    output logic                is_branch,
    output logic                taken,
    output logic [31:0]         target,
    output logic                mispredict
);

    logic [31:0] b;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;

    assign pc_plus4    = pc + 32'd4;
    assign pc_plus_imm = pc + imm;

    always_comb begin
        b          = uses_imm(op) ? imm : vk;
        value      = '0;
        is_branch  = 1'b0;
        taken      = 1'b0;
        target     = pc_plus4;
        case (alu_op_e'(op))
            OP_ADD,  OP_ADDI:  value = vj + b;
            OP_SUB:            value = vj - b;
            OP_AND,  OP_ANDI:  value = vj & b;
            OP_OR,   OP_ORI:   value = vj | b;
            OP_XOR,  OP_XORI:  value = vj ^ b;
            OP_SLL,  OP_SLLI:  value = vj << b[4:0];
            OP_SRL,  OP_SRLI:  value = vj >> b[4:0];
            OP_SRA,  OP_SRAI:  value = $signed(vj) >>> b[4:0];
            OP_SLT,  OP_SLTI:  value = {31'd0, $signed(vj) < $signed(b)};
            OP_SLTU, OP_SLTIU: value = {31'd0, vj < b};
            OP_LUI:            value = imm;
            OP_AUIPC:          value = pc_plus_imm;
            OP_BEQ:  begin is_branch = 1'b1; taken = (vj == vk); end
            OP_BNE:  begin is_branch = 1'b1; taken = (vj != vk); end
            OP_BLT:  begin is_branch = 1'b1; taken = ($signed(vj) <  $signed(vk)); end
            OP_BGE:  begin is_branch = 1'b1; taken = ($signed(vj) >= $signed(vk)); end
            OP_BLTU: begin is_branch = 1'b1; taken = (vj <  vk); end
            OP_BGEU: begin is_branch = 1'b1; taken = (vj >= vk); end
            OP_JAL, OP_JALR: begin
                is_branch = 1'b1;
                taken     = 1'b1;
                value     = pc_plus4;
            end
            default: ;
        endcase
        // Every taken transfer goes to pc+imm except JALR, which is register-relative.
        if (taken)
            target = (alu_op_e'(op) == OP_JALR) ? ((vj + imm) & 32'hFFFF_FFFE) : pc_plus_imm;
        mispredict = is_branch && (target != pred_target);
    end

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - ALU functional unit: evaluates issued ops and queues results for the CDB.
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int RES_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [OP_WIDTH-1:0]     in_op,
    input  logic [31:0]             in_vj,
    input  logic [31:0]             in_vk,
    input  logic [31:0]             in_imm,
    input  logic [31:0]             in_pc,
    input  logic [31:0]             in_pred_target,
    input  logic [ROB_ID_WIDTH-1:0] in_dest,
    output logic                    fu_ready,
    output logic                    cdb_req,
    input  logic                    cdb_grant,
    output logic [ROB_ID_WIDTH-1:0] cdb_rob_id,
    output logic [31:0]             cdb_value,
    output logic                    cdb_is_branch,
    output logic                    cdb_taken,
    output logic [31:0]             cdb_target,
    output logic                    cdb_mispredict
);

    alu_result_t mem [2];
    alu_result_t new_entry;
    alu_result_t head;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    alu_core u_core (
        .op          (in_op),
        .vj          (in_vj),
        .vk          (in_vk),
        .imm         (in_imm),
        .pc          (in_pc),
        .pred_target (in_pred_target),
        .value       (new_entry.value),
        .is_branch   (new_entry.is_branch),
        .taken       (new_entry.taken),
        .target      (new_entry.target),
        .mispredict  (new_entry.mispredict)
    );
    assign new_entry.rob_id = in_dest;

    assign cdb_req  = (count != 2'd0);
    assign fu_ready = (count < 2'(RES_DEPTH));
    assign pop      = cdb_req && cdb_grant;
    // A push into a full buffer is only legal when the head leaves this cycle.
    assign push     = in_valid && ((count != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Data outputs read zero whenever nothing is being requested.
    assign head           = cdb_req ? mem[rd_ptr] : '0;
    assign cdb_rob_id     = head.rob_id;
    assign cdb_value      = head.value;
    assign cdb_is_branch  = head.is_branch;
    assign cdb_taken      = head.taken;
    assign cdb_target     = head.target;
    assign cdb_mispredict = head.mispredict;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - directed and randomized self-checking bench for alu_unit.
module tb_alu_unit;
    import alu_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, cdb_grant;
    logic [4:0]  in_op;
    logic [31:0] in_vj, in_vk, in_imm, in_pc, in_pred_target;
    logic [3:0]  in_dest;
    logic        fu_ready, cdb_req, cdb_is_branch, cdb_taken, cdb_mispredict;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value, cdb_target;

    always #5 clk = ~clk;

    alu_unit #(.RES_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_op(in_op),
        .in_vj(in_vj), .in_vk(in_vk), .in_imm(in_imm), .in_pc(in_pc),
        .in_pred_target(in_pred_target), .in_dest(in_dest), .fu_ready(fu_ready),
        .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_rob_id(cdb_rob_id),
        .cdb_value(cdb_value), .cdb_is_branch(cdb_is_branch), .cdb_taken(cdb_taken),
        .cdb_target(cdb_target), .cdb_mispredict(cdb_mispredict)
    );

    typedef struct {
        logic [3:0]  rob;
        logic [31:0] value;
        logic        is_br;
        logic        taken;
        logic [31:0] target;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_eval(input logic [4:0] op, input logic [31:0] a, k, imm, pc, pred,
                                      input logic [3:0] dest);
        exp_t r;
        r.rob = dest; r.value = 0; r.is_br = 0; r.taken = 0; r.target = pc + 32'd4; r.mis = 0;
        case (op)
            OP_ADD:   r.value = a + k;
            OP_SUB:   r.value = a - k;
            OP_AND:   r.value = a & k;
            OP_OR:    r.value = a | k;
            OP_XOR:   r.value = a ^ k;
            OP_SLL:   r.value = a << k[4:0];
            OP_SRL:   r.value = a >> k[4:0];
            OP_SRA:   r.value = $signed(a) >>> k[4:0];
            OP_SLT:   r.value = (int'(a) < int'(k)) ? 1 : 0;
            OP_SLTU:  r.value = (a < k) ? 1 : 0;
            OP_ADDI:  r.value = a + imm;
            OP_ANDI:  r.value = a & imm;
            OP_ORI:   r.value = a | imm;
            OP_XORI:  r.value = a ^ imm;
            OP_SLLI:  r.value = a << imm[4:0];
            OP_SRLI:  r.value = a >> imm[4:0];
            OP_SRAI:  r.value = $signed(a) >>> imm[4:0];
            OP_SLTI:  r.value = (int'(a) < int'(imm)) ? 1 : 0;
            OP_SLTIU: r.value = (a < imm) ? 1 : 0;
            OP_LUI:   r.value = imm;
            OP_AUIPC: r.value = pc + imm;
            OP_BEQ:   r.taken = (a == k);
            OP_BNE:   r.taken = (a != k);
            OP_BLT:   r.taken = (int'(a) < int'(k));
            OP_BGE:   r.taken = (int'(a) >= int'(k));
            OP_BLTU:  r.taken = (a < k);
            OP_BGEU:  r.taken = (a >= k);
            OP_JAL:   begin r.is_br = 1; r.taken = 1; r.value = pc + 4; r.target = pc + imm; end
            OP_JALR:  begin r.is_br = 1; r.taken = 1; r.value = pc + 4;
                            r.target = (a + imm) & 32'hFFFF_FFFE; end
            default: ;
        endcase
        if (op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU}) begin
            r.is_br  = 1;
            r.target = r.taken ? pc + imm : pc + 32'd4;
        end
        r.mis = r.is_br && (r.target != pred);
        return r;
    endfunction

    task automatic check_outputs();
        check("cdb_req", cdb_req, q.size() != 0);
        check("fu_ready", fu_ready, q.size() < 2);
        if (q.size() != 0) begin
            check("rob_id", cdb_rob_id, q[0].rob);
            check("value", cdb_value, q[0].value);
            check("is_branch", cdb_is_branch, q[0].is_br);
            check("taken", cdb_taken, q[0].taken);
            check("target", cdb_target, q[0].target);
            check("mispredict", cdb_mispredict, q[0].mis);
        end
    endtask

    task automatic tick();
        check_outputs();
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && cdb_grant) void'(q.pop_front());
            if (in_valid) q.push_back(ref_eval(in_op, in_vj, in_vk, in_imm, in_pc, in_pred_target, in_dest));
        end
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] vj, vk, imm, pc, pred,
                         input logic [3:0] dest);
        in_valid = 1; in_op = op; in_vj = vj; in_vk = vk; in_imm = imm;
        in_pc = pc; in_pred_target = pred; in_dest = dest;
        tick();
        in_valid = 0;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    logic prev_valid;

    initial begin
        rst = 1; flush = 0; in_valid = 0; cdb_grant = 0; in_op = 0;
        in_vj = 0; in_vk = 0; in_imm = 0; in_pc = 0; in_pred_target = 0; in_dest = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check("reset_req", cdb_req, 0);
        check("reset_ready", fu_ready, 1);
        check("reset_value", cdb_value, 0);
        check("reset_rob", cdb_rob_id, 0);
        check("reset_target", cdb_target, 0);
        check("reset_flags", {cdb_is_branch, cdb_taken, cdb_mispredict}, 0);

        cdb_grant = 1;
        issue(OP_ADD, 5, 7, 0, 0, 0, 3);
        check("add_req", cdb_req, 1);
        check("add_rob", cdb_rob_id, 3);
        check("add_value", cdb_value, 12);
        tick();
        check("add_req_after_grant", cdb_req, 0);

        issue(OP_SRA, 32'h8000_0000, 4, 0, 0, 0, 1);
        check("sra_value", cdb_value, 32'hF800_0000);
        tick();
        issue(OP_SLTU, 1, 32'hFFFF_FFFF, 0, 0, 0, 2);
        check("sltu_value", cdb_value, 1);
        tick();
        issue(OP_SLT, 1, 32'hFFFF_FFFF, 0, 0, 0, 2);
        check("slt_value", cdb_value, 0);
        tick();
        issue(OP_BEQ, 9, 9, 32'h20, 32'h100, 32'h104, 4);
        check("beq_t_taken", cdb_taken, 1);
        check("beq_t_target", cdb_target, 32'h120);
        check("beq_t_mis", cdb_mispredict, 1);
        tick();
        issue(OP_BEQ, 9, 8, 32'h20, 32'h100, 32'h104, 5);
        check("beq_nt_target", cdb_target, 32'h104);
        check("beq_nt_mis", cdb_mispredict, 0);
        tick();
        issue(OP_JALR, 32'h203, 0, 0, 32'h40, 32'h200, 6);
        check("jalr_value", cdb_value, 32'h44);
        check("jalr_target", cdb_target, 32'h202);
        check("jalr_mis", cdb_mispredict, 1);
        tick();

        // Back-pressure: two results stall, one grant releases the oldest.
        cdb_grant = 0;
        issue(OP_ADDI, 100, 0, 1, 0, 0, 7);
        tick();
        issue(OP_XOR, 32'hF0F0, 32'h0FF0, 0, 0, 0, 8);
        check("stall_full_ready", fu_ready, 0);
        tick();
        tick();
        cdb_grant = 1;
        tick();
        cdb_grant = 0;
        check("stall_ready_after_pop", fu_ready, 1);
        check("stall_second_value", cdb_value, 32'hFF00);
        check("stall_second_rob", cdb_rob_id, 8);

        issue(OP_LUI, 0, 0, 32'h1234_5000, 0, 0, 9);
        check("flush_pre_ready", fu_ready, 0);
        flush = 1;
        issue(OP_ADD, 1, 1, 0, 0, 0, 10);
        flush = 0;
        check("flush_req", cdb_req, 0);
        tick();
        check("flush_drop_issue", cdb_req, 0);

        prev_valid = 0;
        repeat (800) begin
            cdb_grant = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = !prev_valid && $urandom_range(0, 1) &&
                        (q.size() < 2 || cdb_grant || flush);
            in_op   = 5'($urandom_range(0, 31));
            in_vj   = rnd_word();
            in_vk   = ($urandom_range(0, 3) == 0) ? in_vj : rnd_word();
            in_imm  = rnd_word();
            in_pc   = $urandom & 32'hFFFF_FFFC;
            in_dest = 4'($urandom);
            case ($urandom_range(0, 2))
                0: in_pred_target = in_pc + 32'd4;
                1: in_pred_target = in_pc + in_imm;
                default: in_pred_target = $urandom;
            endcase
            tick();
            prev_valid = in_valid;
        end
        in_valid = 0; flush = 0; cdb_grant = 1;
        repeat (3) tick();
        check("drain_req", cdb_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
